// File: rtl/ram_pkg.sv
// Shared types and helpers for the masked dual-port RAM.
// Lanes up to 64 bits wide are supported by even_par.
package ram_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    function automatic int num_lanes(int data_w, int lane_w);
        return data_w / lane_w;
    endfunction

    function automatic logic even_par(logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ram_dp_masked_if.sv
// Port bundle for ram_dp_masked.
// RAM_PARITY_EN adds the rd_perr signal.
interface ram_dp_masked_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int LANE_W = 8
);
    import ram_pkg::*;

    localparam int NUM_LANES = num_lanes(DATA_W, LANE_W);

    logic                 clr_req;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_LANES-1:0] wr_mask;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 init_done;
`ifdef RAM_PARITY_EN
    logic                 rd_perr;
`endif

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, wr_mask,
        output rd_en, rd_addr,
        input  rd_data, rd_valid, init_done
`ifdef RAM_PARITY_EN
        , input rd_perr
`endif
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, wr_mask,
        input  rd_en, rd_addr,
        output rd_data, rd_valid, init_done
`ifdef RAM_PARITY_EN
        , output rd_perr
`endif
    );

endinterface

// File: rtl/ram_clear_ctrl.sv
// CLEAR/RUN sequencer: sweeps zeros through the array after
// reset or on clr_req, then raises init_done.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign clr_addr  = cnt_q[ADDR_W-1:0];
    assign init_done = (state_q == RUN);

endmodule

// File: rtl/ram_dp_masked.sv
// Simple dual-port RAM with lane masks, write-first bypass and clear
// engine. Define RAM_PARITY_EN for per-lane even parity and rd_perr.
module ram_dp_masked
    import ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int LANE_W = 8
) (
    input logic           clk,
    input logic           rst,
    ram_dp_masked_if.slave bus
);
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int NUM_LANES = num_lanes(DATA_W, LANE_W);

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
    logic [NUM_LANES-1:0] par [DEPTH];
    logic                 perr_d;
`endif

    logic                 clr_we;
    logic [ADDR_W-1:0]    clr_addr;
    logic                 run_wr;
    logic                 rd_go;
    logic                 byp;
    logic [ADDR_W-1:0]    wa;
    logic [DATA_W-1:0]    wd;
    logic [NUM_LANES-1:0] wm;
    logic [DATA_W-1:0]    rd_word;

    ram_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (bus.clr_req),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (bus.init_done)
    );

    // clr_req wins over any port access in the same cycle
    always_comb begin
        run_wr = bus.init_done && bus.wr_en && !bus.clr_req;
        rd_go  = bus.init_done && bus.rd_en && !bus.clr_req;
        wa     = clr_we ? clr_addr : bus.wr_addr;
        wd     = clr_we ? '0 : bus.wr_data;
        wm     = clr_we ? '1 : (run_wr ? bus.wr_mask : '0);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wm[i]) begin
                mem[wa][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
`ifdef RAM_PARITY_EN
                par[wa][i] <= even_par(64'(wd[i*LANE_W +: LANE_W]));
`endif
            end
        end
    end

    always_comb begin
        byp     = run_wr && (bus.wr_addr == bus.rd_addr);
        rd_word = mem[bus.rd_addr];
`ifdef RAM_PARITY_EN
        perr_d  = 1'b0;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
            if (byp && bus.wr_mask[i]) begin
                rd_word[i*LANE_W +: LANE_W] = bus.wr_data[i*LANE_W +: LANE_W];
            end
`ifdef RAM_PARITY_EN
            else if (par[bus.rd_addr][i] !=
                     even_par(64'(mem[bus.rd_addr][i*LANE_W +: LANE_W]))) begin
                perr_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
`ifdef RAM_PARITY_EN
            bus.rd_perr  <= 1'b0;
`endif
        end else begin
            bus.rd_valid <= rd_go;
            if (rd_go) begin
                bus.rd_data <= rd_word;
            end
`ifdef RAM_PARITY_EN
            bus.rd_perr  <= rd_go && perr_d;
`endif
        end
    end

endmodule
